// File: rtl/mdu_seq.sv
// mdu_seq: iterative shift-add multiply / restoring divide sequencer sharing an external ALU.
// Define MDU_SIGNED_EN to add signed operations (op_i[1]) and the FIX correction state.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             cancel_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_sel_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_cout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef MDU_SIGNED_EN
        S_FIX  = 2'd3,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    cnt_q;
    logic             op_div_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             dbz_q;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] a_load, b_load;
    logic             start_dbz, last_iter;

    assign start_dbz = op_i[0] && (src_b_i == '0);
    assign last_iter = (cnt_q == CNT_LAST);
    assign rem_shift = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};

`ifdef MDU_SIGNED_EN
    logic                 sgn_q, neg_a_q, neg_b_q;
    logic                 neg_a, neg_b;
    logic [2*WIDTH-1:0]   prod_neg;

    // Iterations run on magnitudes; signs are reapplied in FIX.
    assign neg_a    = op_i[1] & src_a_i[WIDTH-1];
    assign neg_b    = op_i[1] & src_b_i[WIDTH-1];
    assign a_load   = neg_a ? -src_a_i : src_a_i;
    assign b_load   = neg_b ? -src_b_i : src_b_i;
    assign prod_neg = -{hi_q, lo_q};
`else
    logic unused_op;
    assign unused_op = op_i[1];
    assign a_load    = src_a_i;
    assign b_load    = src_b_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cancel_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: state_d = start_i ? (start_dbz ? S_DONE : S_RUN) : S_IDLE;
                S_RUN: begin
                    if (last_iter) begin
`ifdef MDU_SIGNED_EN
                        state_d = sgn_q ? S_FIX : S_DONE;
`else
                        state_d = S_DONE;
`endif
                    end
                end
`ifdef MDU_SIGNED_EN
                S_FIX: state_d = S_DONE;
`endif
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_RUN);
`ifdef MDU_SIGNED_EN
        if (state_d == S_FIX) busy_d = 1'b1;
`endif
    end

    always_comb begin
        alu_sel_o = ALU_ADD;
        alu_a_o   = '0;
        alu_b_o   = '0;
        done_o    = (state_q == S_DONE);
        busy_o    = busy_q;
        if (state_q == S_RUN) begin
            if (op_div_q) begin
                alu_sel_o = ALU_SUB;
                alu_a_o   = rem_shift;
                alu_b_o   = m_q;
            end else begin
                alu_a_o = acc_q;
                alu_b_o = q_q[0] ? m_q : '0;
            end
        end
    end

    // One iteration step; acc[MSB] set means the shifted remainder already exceeds any divisor.
    always_comb begin
        if (op_div_q) begin
            if (acc_q[WIDTH-1] | alu_cout_i) begin
                acc_d = alu_result_i;
                q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = rem_shift;
                q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {alu_cout_i, alu_result_i[WIDTH-1:1]};
            q_d   = {alu_result_i[0], q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
`ifdef MDU_SIGNED_EN
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
`endif
        end else if (!cancel_i) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        q_q      <= a_load;
                        m_q      <= b_load;
                        op_div_q <= op_i[0];
`ifdef MDU_SIGNED_EN
                        sgn_q    <= op_i[1];
                        neg_a_q  <= neg_a;
                        neg_b_q  <= neg_b;
`endif
                        if (start_dbz) begin
                            hi_q  <= src_a_i;
                            lo_q  <= '1;
                            dbz_q <= 1'b1;
                        end else begin
                            dbz_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        hi_q <= acc_d;
                        lo_q <= q_d;
                    end
                end
`ifdef MDU_SIGNED_EN
                S_FIX: begin
                    if (!op_div_q) begin
                        if (neg_a_q ^ neg_b_q) {hi_q, lo_q} <= prod_neg;
                    end else begin
                        if (neg_a_q ^ neg_b_q) lo_q <= -lo_q;
                        if (neg_a_q) hi_q <= -hi_q;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: random and directed ops checked against a plain-arithmetic model.
module tb_mdu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, cancel;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b, alu_a, alu_b, alu_result, hi, lo;
    logic [2:0]   alu_sel;
    logic         alu_cout, busy, done, dbz;
    logic [W:0]   alu_sum;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .src_a_i(src_a), .src_b_i(src_b), .cancel_i(cancel),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
        .alu_result_i(alu_result), .alu_cout_i(alu_cout),
        .busy_o(busy), .done_o(done), .div_by_zero_o(dbz),
        .hi_o(hi), .lo_o(lo)
    );

    // Shared ALU: ADD or SUB as a + ~b + 1.
    always_comb begin
        if (alu_sel == 3'b110) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                   alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_result = alu_sum[W-1:0];
    assign alu_cout   = alu_sum[W];

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           done_cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    logic [W-1:0] held_hi = '0;
    logic [W-1:0] held_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] o, input int e0);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sbv, qq, rr;
        bit          is_signed;
`ifdef MDU_SIGNED_EN
        is_signed = o[1];
`else
        is_signed = 1'b0;
`endif
        e.dbz = 1'b0;
        if (o[0] && b == '0) begin
            e.hi = a; e.lo = '1; e.dbz = 1'b1; e.done_cyc = e0;
        end else if (!is_signed) begin
            if (o[0]) begin
                e.lo = a / b; e.hi = a % b;
            end else begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            e.done_cyc = e0 + W;
        end else begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            if (o[0]) begin
                qq = sa / sbv; rr = sa % sbv;
                e.lo = qq[31:0]; e.hi = rr[31:0];
            end else begin
                p = sa * sbv;
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            e.done_cyc = e0 + W + 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending op", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("div_by_zero", 64'(dbz), 64'(e.dbz));
                chk("done_latency", 64'(cyc), 64'(e.done_cyc));
                chk("busy_at_done", 64'(busy), 64'd0);
                held_hi = e.hi;
                held_lo = e.lo;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] o, input bit push);
        exp_t e;
        start = 1'b1; src_a = a; src_b = b; op = o;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e = model(a, b, o, cyc);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 80);
        chk({name, "_done_seen"}, 64'(done), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dbz", 64'(dbz), 64'd0);
        chk("rst_alu_sel", 64'(alu_sel), 64'h2);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        rst = 1'b0;

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1); wait_done("mul_max");
        issue(32'd0, 32'd5, 2'b00, 1'b1);                wait_done("mul_zero");
        issue(32'd100, 32'd7, 2'b01, 1'b1);              wait_done("div_100_7");
        issue(32'h8000_0000, 32'd1, 2'b01, 1'b1);        wait_done("div_msb_1");
        issue(32'd5, 32'd0, 2'b01, 1'b1);
        chk("dbz_busy", 64'(busy), 64'd0);
        wait_done("div_zero");
`ifdef MDU_SIGNED_EN
        issue(-32'sd7, 32'd2, 2'b11, 1'b1);              wait_done("sdiv_m7_2");
        issue(-32'sd3, 32'd4, 2'b10, 1'b1);              wait_done("smul_m3_4");
`endif

        // Back-to-back: the second start lands in the DONE cycle of the first.
        issue(32'd12345, 32'd678, 2'b00, 1'b1); wait_done("b2b_first");
        issue(32'd99999, 32'd13, 2'b01, 1'b1);  wait_done("b2b_second");

        // Start during RUN is ignored; cancel aborts without touching results.
        issue(32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; src_a = 32'd5; src_b = 32'd0; op = 2'b01;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignored_start_busy", 64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_done", 64'(done), 64'd0);
        chk("cancel_hi", 64'(hi), 64'(held_hi));
        chk("cancel_lo", 64'(lo), 64'(held_lo));
        repeat (40) @(negedge clk);
        chk("cancel_hi_hold", 64'(hi), 64'(held_hi));
        chk("cancel_lo_hold", 64'(lo), 64'(held_lo));

        // Cancel beats start in the DONE cycle.
        issue(32'd77, 32'd3, 2'b01, 1'b1); wait_done("pre_cancel");
        start = 1'b1; cancel = 1'b1; src_a = 32'd9; src_b = 32'd9; op = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        chk("cancel_prio_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        chk("cancel_prio_lo", 64'(lo), 64'(held_lo));

        // Reset in the middle of a multiply.
        issue(32'hDEAD_BEEF, 32'h0000_1234, 2'b00, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_alu_sel", 64'(alu_sel), 64'h2);
        rst = 1'b0;
        held_hi = '0;
        held_lo = '0;
        repeat (40) @(negedge clk);
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_hi", 64'(hi), 64'd0);

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            int           kind;
            a    = $urandom;
            kind = $urandom_range(0, 3);
            if (kind == 0)      b = '0;
            else if (kind == 1) b = W'($urandom_range(1, 15));
            else                b = $urandom;
            issue(a, b, 2'($urandom_range(0, 3)), 1'b1);
            wait_done("random");
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the EX stage. It reuses the shared 32-bit ALU, using ADD and SUB selects, one ALU operation per clock. Unsigned multiply uses shift-add over WIDTH cycles; unsigned divide uses restoring division over WIDTH cycles. Results are written to architectural HI/LO registers, and the pipeline is held off via `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; also the number of iterations.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only when the state is IDLE or DONE.
- `op` in 2: bit0 selects 0 = multiply, 1 = divide. Bit1 selects signed, and only when `MDU_SIGNED_EN` is defined.
- `src_a` in WIDTH: multiplicand or dividend.
- `src_b` in WIDTH: multiplier or divisor.
- `cancel` in 1: pipeline flush; aborts the operation in flight.
- `alu_a` out WIDTH: ALU operand A.
- `alu_b` out WIDTH: ALU operand B.
- `alu_sel` out 3: ALU select, 3'b010 = ADD, 3'b110 = SUB.
- `alu_result` in WIDTH: combinational ALU sum, valid in the same cycle.
- `alu_cout` in 1: ALU carry-out. For SUB (a + ~b + 1), 1 means a >= b unsigned.
- `busy` out 1: an operation is in flight (RUN or FIX).
- `done` out 1: one-cycle completion pulse.
- `div_by_zero` out 1: the last completed divide had divisor 0.
- `hi` out WIDTH: product high half, or remainder.
- `lo` out WIDTH: product low half, or quotient.

## Operation
States: IDLE, RUN, FIX (signed builds only), DONE.
- Working registers are `acc`, `q`, `m`, a 0..WIDTH-1 count `cnt`, and the latched `op`.
- `hi`/`lo` are written only on completion.

Start handling:
- `start` in IDLE or DONE latches the operands and clears `acc` and `cnt`.
- Multiply: `q` = `src_a`, `m` = `src_b`.
- Divide: `q` = `src_a`, `m` = `src_b`.
- Divide with `src_b` == 0: go directly to DONE with `hi` = `src_a`, `lo` = all ones, `div_by_zero` = 1.
- Otherwise go to RUN, with `div_by_zero` = 0.

RUN, multiply:
- ALU drives `alu_a` = `acc`, `alu_b` = `q[0]` ? `m` : 0, `alu_sel` = ADD.
- Update: `acc` <= {`alu_cout`, `alu_result[WIDTH-1:1]`}, `q` <= {`alu_result[0]`, `q[WIDTH-1:1]`}.

RUN, divide:
- Form r = {`acc[WIDTH-2:0]`, `q[WIDTH-1]`}.
- ALU drives `alu_a` = r, `alu_b` = `m`, `alu_sel` = SUB.
- If `acc[WIDTH-1]` | `alu_cout`: `acc` <= `alu_result`, `q` <= {`q[WIDTH-2:0]`, 1}.
- Else: `acc` <= r, `q` <= {`q[WIDTH-2:0]`, 0}.

RUN exit:
- At `cnt` == WIDTH-1, the final update goes straight to `hi` <= `acc`-next and `lo` <= `q`-next.
- Next state is DONE, or FIX for signed ops.

Idle ALU drive:
- Outside RUN: `alu_sel` = ADD, `alu_a` = 0, `alu_b` = 0.

DONE:
- `done` = 1 for exactly one cycle.
- Next state is IDLE, or RUN/DONE if `start` is high.

`cancel`:
- Any state returns to IDLE on the next edge.
- No `done`; `hi`, `lo` and `div_by_zero` are unchanged.
- `cancel` has priority over `start` in the same cycle.

`start` while `busy`: ignored; the operation in flight is unaffected.

Arithmetic: all unsigned modulo 2^WIDTH. The multiply product is the full 2·WIDTH bits in {`hi`, `lo`}.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `div_by_zero` = 0, `hi` = 0, `lo` = 0, `cnt` = 0, `alu_sel` = 3'b010, `alu_a` = 0, `alu_b` = 0.
- Edge E0 samples `start`. `busy` goes high after E0, and RUN iterations occur at E1..EWIDTH.
- After EWIDTH, `hi`/`lo` are valid and held, `done` = 1, and `busy` = 0.
- Unsigned latency: `done` is high in the cycle following edge WIDTH after E0.
- Signed latency: one extra edge (FIX).
- Divide-by-zero latency: `done` is high in the cycle right after E0, and `busy` never asserts.
- Back-to-back: `start` in the DONE cycle is accepted, with no idle gap.
- `busy` is registered. The hazard unit stalls on `start` | `busy`.

## Configuration
`MDU_SIGNED_EN`, when defined:
- `op[1]` = 1 selects a signed operation.
- At start, negative operands are replaced by their magnitudes (internal negation), and the sign information is latched.
- FIX state, multiply: negates {`hi`, `lo`} if the signs differ.
- FIX state, divide: negates `lo` if the signs differ, and negates `hi` if the dividend is negative.
- Signed ops always take the FIX cycle.
- Divide-by-zero behaviour is unchanged: `hi` = `src_a`, `lo` = all ones.

When undefined: `op[1]` is ignored, all ops are unsigned, and there is no FIX state or negation logic.

## Test plan
All scenarios use WIDTH = 32.
- **Reset:** hold `rst` 2 cycles mid-multiply → `busy` = 0, `done` = 0, `hi` = `lo` = 0, `alu_sel` = 3'b010; no `done` afterwards.
- **Unsigned multiply:** 0xFFFFFFFF × 0xFFFFFFFF → `done` 32 edges after start, `hi` = 0xFFFFFFFE, `lo` = 0x00000001. Also 0 × 5 → `hi` = `lo` = 0.
- **Unsigned divide:** 100 / 7 → `lo` = 14, `hi` = 2, `div_by_zero` = 0. Also 0x80000000 / 1 → `lo` = 0x80000000, `hi` = 0.
- **Divide by zero:** 5 / 0 → `done` in the cycle after the start edge, `busy` stays 0, `hi` = 5, `lo` = 0xFFFFFFFF, `div_by_zero` = 1.
- **Cancel and ignored start:** assert `cancel` at iteration 10 of a multiply, with `start` pulsed at iteration 5 → state IDLE next edge, no `done`, `hi`/`lo` keep their prior values. A back-to-back `start` in the DONE cycle completes 32 edges later.
- **Signed (`MDU_SIGNED_EN`):** -7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF, `done` 33 edges after start. -3 × 4 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF4.
